// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module   : hazard_control_unit
// Purpose  : Pipeline sequencer for the 5-stage IF/OF/EX/MA/RW processor.
//            Detects RAW data hazards between the IF/OF instruction and the
//            in-flight writers in OF/EX, EX/MA and MA/RW. The pipeline has no
//            forwarding, so all three writers are checked. Also handles the
//            control hazard from a taken branch resolved in EX. Drives the
//            PC hold, IF/OF hold/flush and OF/EX bubble controls. Keeps
//            saturating stall/flush statistics and a sticky stall watchdog.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            ifof_*                     - decoded fields of the IF/OF instruction
//            {ofex,exma,marw}_wr_*      - pending register writes per stage
//            branch_taken               - taken branch resolved in EX
//            pc_hold, ifof_hold         - freeze PC / re-present IF/OF
//            ifof_flush, ofex_bubble    - load NOP into IF/OF / bubble OF/EX
//            state                      - 0=RUN, 1=DSTALL, 2=FLUSH
//            stall_count, flush_count   - saturating statistics
//            stall_timeout              - sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_control_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 8,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ifof_valid,
    input  logic [3:0]       ifof_opcode,
    input  logic [3:0]       ifof_src_a,
    input  logic [3:0]       ifof_src_b,
    input  logic             ofex_wr_en,
    input  logic [3:0]       ofex_wr_addr,
    input  logic             exma_wr_en,
    input  logic [3:0]       exma_wr_addr,
    input  logic             marw_wr_en,
    input  logic [3:0]       marw_wr_addr,
    input  logic             branch_taken,
    output logic             pc_hold,
    output logic             ifof_hold,
    output logic             ifof_flush,
    output logic             ofex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             stall_timeout
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DSTALL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam int                    c_consec_w     = $clog2(MAX_STALL + 1);
    localparam logic [3:0]            c_flush_reload = 4'(FLUSH_CYCLES - 1);
    localparam logic [c_consec_w-1:0] c_max_stall    = c_consec_w'(MAX_STALL);
    localparam logic [CNT_W-1:0]      c_cnt_max      = '1;

    state_t                  state_q,         state_d;
    logic [3:0]              flush_left_q,    flush_left_d;
    logic [c_consec_w-1:0]   consec_q,        consec_d;
    logic [CNT_W-1:0]        stall_count_q,   stall_count_d;
    logic [CNT_W-1:0]        flush_count_q,   flush_count_d;
    logic                    stall_timeout_q, stall_timeout_d;

    logic w_uses_a;
    logic w_uses_b;
    logic w_uses_flag;
    logic w_dep_ofex;
    logic w_dep_exma;
    logic w_dep_marw;
    logic w_hazard;

    // ------------------------------------------------------------------
    // Source-use decode. opcode[1:0]=11 marks single-source (ALU) or
    // flag-only / no-source (control) forms. The flag lives in r15.
    // ------------------------------------------------------------------
    always_comb begin
        w_uses_a    = 1'b0;
        w_uses_b    = 1'b0;
        w_uses_flag = 1'b0;
        if (ifof_valid) begin
            if (!ifof_opcode[3]) begin
                w_uses_a = 1'b1;
                w_uses_b = (ifof_opcode[1:0] != 2'b11);
            end else if (ifof_opcode[1:0] != 2'b11) begin
                w_uses_a = ifof_opcode[1];
            end else begin
                w_uses_flag = (ifof_opcode == 4'b1011);
            end
        end
    end

    // Register 0 is an ordinary register here, so no zero-address exemption.
    always_comb begin
        w_dep_ofex = ofex_wr_en &&
                     ((w_uses_a    && (ofex_wr_addr == ifof_src_a)) ||
                      (w_uses_b    && (ofex_wr_addr == ifof_src_b)) ||
                      (w_uses_flag && (ofex_wr_addr == 4'hF)));
        w_dep_exma = exma_wr_en &&
                     ((w_uses_a    && (exma_wr_addr == ifof_src_a)) ||
                      (w_uses_b    && (exma_wr_addr == ifof_src_b)) ||
                      (w_uses_flag && (exma_wr_addr == 4'hF)));
        w_dep_marw = marw_wr_en &&
                     ((w_uses_a    && (marw_wr_addr == ifof_src_a)) ||
                      (w_uses_b    && (marw_wr_addr == ifof_src_b)) ||
                      (w_uses_flag && (marw_wr_addr == 4'hF)));
        w_hazard   = w_dep_ofex || w_dep_exma || w_dep_marw;
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs. Controls are combinational so the
    // pipeline registers act on them at the coming edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        flush_left_d    = flush_left_q;
        consec_d        = '0;
        stall_count_d   = stall_count_q;
        flush_count_d   = flush_count_q;
        stall_timeout_d = stall_timeout_q;
        pc_hold         = 1'b0;
        ifof_hold       = 1'b0;
        ifof_flush      = 1'b0;
        ofex_bubble     = 1'b0;

        case (state_q)
            ST_FLUSH: begin
                // Slots being flushed carry bubbles, so hazards and further
                // branches are irrelevant until the front end refills.
                ifof_flush  = 1'b1;
                ofex_bubble = 1'b1;
                if (flush_left_q <= 4'd1) begin
                    flush_left_d = 4'd0;
                    state_d      = ST_RUN;
                end else begin
                    flush_left_d = flush_left_q - 4'd1;
                end
            end
            default: begin
                if (branch_taken) begin
                    // Flush wins over a pending stall; the hold is dropped.
                    ifof_flush  = 1'b1;
                    ofex_bubble = 1'b1;
                    if (flush_count_q != c_cnt_max) begin
                        flush_count_d = flush_count_q + 1'b1;
                    end
                    if (FLUSH_CYCLES > 1) begin
                        state_d      = ST_FLUSH;
                        flush_left_d = c_flush_reload;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (w_hazard) begin
                    pc_hold     = 1'b1;
                    ifof_hold   = 1'b1;
                    ofex_bubble = 1'b1;
                    if (stall_count_q != c_cnt_max) begin
                        stall_count_d = stall_count_q + 1'b1;
                    end
                    // The stall cycle issued from RUN is the first of a run.
                    if (state_q == ST_DSTALL) begin
                        consec_d = (consec_q == c_max_stall) ? consec_q
                                                             : consec_q + 1'b1;
                    end else begin
                        consec_d = {{(c_consec_w-1){1'b0}}, 1'b1};
                    end
                    if (consec_d == c_max_stall) begin
                        stall_timeout_d = 1'b1;
                    end
                    state_d = ST_DSTALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            flush_left_q    <= 4'd0;
            consec_q        <= '0;
            stall_count_q   <= '0;
            flush_count_q   <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_left_q    <= flush_left_d;
            consec_q        <= consec_d;
            stall_count_q   <= stall_count_d;
            flush_count_q   <= flush_count_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign state         = state_q;
    assign stall_count   = stall_count_q;
    assign flush_count   = flush_count_q;
    assign stall_timeout = stall_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module   : tb_hazard_control_unit
// Purpose  : Self-checking bench for hazard_control_unit: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

    localparam int FC   = 2;
    localparam int MS   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ifof_valid;
    logic [3:0]    ifof_opcode, ifof_src_a, ifof_src_b;
    logic          ofex_wr_en, exma_wr_en, marw_wr_en;
    logic [3:0]    ofex_wr_addr, exma_wr_addr, marw_wr_addr;
    logic          branch_taken;
    logic          pc_hold, ifof_hold, ifof_flush, ofex_bubble;
    logic [1:0]    state;
    logic [CW-1:0] stall_count, flush_count;
    logic          stall_timeout;

    always #5 clk = ~clk;

    hazard_control_unit #(
        .FLUSH_CYCLES (FC),
        .MAX_STALL    (MS),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ifof_valid    (ifof_valid),
        .ifof_opcode   (ifof_opcode),
        .ifof_src_a    (ifof_src_a),
        .ifof_src_b    (ifof_src_b),
        .ofex_wr_en    (ofex_wr_en),
        .ofex_wr_addr  (ofex_wr_addr),
        .exma_wr_en    (exma_wr_en),
        .exma_wr_addr  (exma_wr_addr),
        .marw_wr_en    (marw_wr_en),
        .marw_wr_addr  (marw_wr_addr),
        .branch_taken  (branch_taken),
        .pc_hold       (pc_hold),
        .ifof_hold     (ifof_hold),
        .ifof_flush    (ifof_flush),
        .ofex_bubble   (ofex_bubble),
        .state         (state),
        .stall_count   (stall_count),
        .flush_count   (flush_count),
        .stall_timeout (stall_timeout)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=running, 1=stalled, 2=flushing
    int m_mode, m_left, m_run, m_stall, m_flush;
    bit m_to;

    function automatic bit model_hazard();
        int srcs[$];
        bit en[3];
        int ad[3];
        int op;
        op = int'(ifof_opcode);
        if (ifof_valid) begin
            if (op < 8) begin
                srcs.push_back(int'(ifof_src_a));
                if (op % 4 != 3) srcs.push_back(int'(ifof_src_b));
            end else if (op % 4 != 3) begin
                if ((op / 2) % 2 == 1) srcs.push_back(int'(ifof_src_a));
            end else if (op == 11) begin
                srcs.push_back(15);
            end
        end
        en[0] = ofex_wr_en; ad[0] = int'(ofex_wr_addr);
        en[1] = exma_wr_en; ad[1] = int'(exma_wr_addr);
        en[2] = marw_wr_en; ad[2] = int'(marw_wr_addr);
        foreach (en[i]) begin
            if (en[i]) begin
                foreach (srcs[j]) if (srcs[j] == ad[i]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // One clock: check comb outputs and registered state, then advance model.
    task automatic cycle();
        bit hz, e_hold, e_flush, e_bub;
        #1;
        hz = model_hazard();
        e_hold = 0; e_flush = 0; e_bub = 0;
        if (m_mode == 2 || branch_taken) begin
            e_flush = 1; e_bub = 1;
        end else if (hz) begin
            e_hold = 1; e_bub = 1;
        end
        chk("state", state, m_mode);
        chk("stall_count", stall_count, m_stall);
        chk("flush_count", flush_count, m_flush);
        chk("stall_timeout", stall_timeout, m_to);
        chk("hold_flush_excl", pc_hold & ifof_flush, 0);
        if (!reset) begin
            chk("pc_hold", pc_hold, e_hold);
            chk("ifof_hold", ifof_hold, e_hold);
            chk("ifof_flush", ifof_flush, e_flush);
            chk("ofex_bubble", ofex_bubble, e_bub);
        end
        @(posedge clk);
        if (reset) begin
            m_mode = 0; m_left = 0; m_run = 0; m_stall = 0; m_flush = 0; m_to = 0;
        end else if (m_mode == 2) begin
            m_left--;
            if (m_left <= 0) m_mode = 0;
            m_run = 0;
        end else if (branch_taken) begin
            if (m_flush < CMAX) m_flush++;
            m_run = 0;
            if (FC > 1) begin m_mode = 2; m_left = FC - 1; end
            else m_mode = 0;
        end else if (hz) begin
            if (m_stall < CMAX) m_stall++;
            m_run = (m_mode == 1) ? m_run + 1 : 1;
            if (m_run >= MS) m_to = 1;
            m_mode = 1;
        end else begin
            m_mode = 0; m_run = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        ifof_valid = 0; ifof_opcode = 0; ifof_src_a = 0; ifof_src_b = 0;
        ofex_wr_en = 0; ofex_wr_addr = 0; exma_wr_en = 0; exma_wr_addr = 0;
        marw_wr_en = 0; marw_wr_addr = 0; branch_taken = 0;
    endtask

    task automatic do_reset();
        reset = 1; cycle(); cycle(); reset = 0;
    endtask

    function automatic logic [3:0] pick_reg();
        return ($urandom % 3 == 0) ? 4'hF : 4'($urandom % 4);
    endfunction

    initial begin
        m_mode = 0; m_left = 0; m_run = 0; m_stall = 0; m_flush = 0; m_to = 0;
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        do_reset();
        cycle();
        chk("reset_state", state, 0);
        chk("reset_stall_cnt", stall_count, 0);

        // RAW from EX/MA for two cycles
        ifof_valid = 1; ifof_opcode = 4'b0000; ifof_src_a = 3; ifof_src_b = 9;
        exma_wr_en = 1; exma_wr_addr = 3;
        #1; chk("raw_pc_hold", pc_hold, 1);
        cycle(); cycle();
        exma_wr_en = 0;
        #1; chk("raw_release_hold", pc_hold, 0);
        chk("raw_stall_cnt", stall_count, 2);
        cycle();
        chk("raw_back_run", state, 0);

        // Reset asserted mid-stall
        exma_wr_en = 1;
        cycle(); cycle();
        do_reset();
        idle_inputs();
        cycle();
        chk("rst_mid_state", state, 0);
        chk("rst_mid_stall_cnt", stall_count, 0);
        chk("rst_mid_pc_hold", pc_hold, 0);

        // src_b unused for opcode 0011, used for 0001
        ifof_valid = 1; ifof_opcode = 4'b0011; ifof_src_a = 7; ifof_src_b = 5;
        ofex_wr_en = 1; ofex_wr_addr = 5;
        #1; chk("srcb_skip", pc_hold, 0);
        cycle();
        ifof_opcode = 4'b0001;
        #1; chk("srcb_used", pc_hold, 1);
        cycle();
        idle_inputs(); cycle();

        // Flag dependency via r15
        ifof_valid = 1; ifof_opcode = 4'b1011; marw_wr_en = 1; marw_wr_addr = 15;
        #1; chk("flag_stall", pc_hold, 1);
        cycle();
        ifof_opcode = 4'b1000;
        #1; chk("flag_nostall", pc_hold, 0);
        cycle();
        idle_inputs(); cycle();

        // Branch while stalled
        do_reset();
        ifof_valid = 1; ifof_opcode = 4'b0000; ifof_src_a = 3; exma_wr_en = 1; exma_wr_addr = 3;
        cycle();
        branch_taken = 1;
        #1; chk("br_flush", ifof_flush, 1);
        chk("br_no_hold", pc_hold, 0);
        cycle();
        branch_taken = 0;
        #1; chk("br_flush2", ifof_flush, 1);
        cycle();
        idle_inputs();
        #1; chk("br_done_run", state, 0);
        chk("br_flush_cnt", flush_count, 1);
        cycle();

        // Watchdog: 10-cycle hazard
        do_reset();
        ifof_valid = 1; ifof_opcode = 4'b0000; ifof_src_a = 0; ofex_wr_en = 1; ofex_wr_addr = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            chk("wd_timeout", stall_timeout, (i >= MS) ? 1 : 0);
        end
        idle_inputs();
        cycle(); cycle();
        chk("wd_sticky", stall_timeout, 1);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ifof_valid   = ($urandom % 4 != 0);
            ifof_opcode  = 4'($urandom % 16);
            ifof_src_a   = pick_reg();
            ifof_src_b   = pick_reg();
            ofex_wr_en   = ($urandom % 3 == 0);
            ofex_wr_addr = pick_reg();
            exma_wr_en   = ($urandom % 3 == 0);
            exma_wr_addr = pick_reg();
            marw_wr_en   = ($urandom % 3 == 0);
            marw_wr_addr = pick_reg();
            branch_taken = ($urandom % 12 == 0);
            reset        = ($urandom % 300 == 0);
            cycle();
        end
        reset = 0;
        idle_inputs();
        cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
